// File: rtl/shift_right_sequencer.sv
// Multi-cycle right shifter: one bit per clock, logical or arithmetic,
// with valid/ready handshakes on operand and result.
module shift_right_sequencer #(
   parameter int WIDTH     = 16,
   parameter int OUT_WIDTH = 32,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in,
   input  logic [CNT_W-1:0]     shamt,
   input  logic                 arith,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] MAXSH = CNT_W'(WIDTH);

   state_t               state, state_n;
   logic [WIDTH-1:0]     data, data_n;
   logic [CNT_W-1:0]     rem, rem_n;
   logic                 mode, mode_n;
   logic [OUT_WIDTH-1:0] out_n;
   logic                 ov_n;
   logic [CNT_W-1:0]     eff;
   logic                 fill;
   logic [WIDTH-1:0]     sh;
   logic [OUT_WIDTH-1:0] ext_in, ext_sh;

   assign in_ready = (state == IDLE) & ~clear & ~reset;
   assign eff      = (shamt >= MAXSH) ? MAXSH : shamt;
   assign fill     = mode & data[WIDTH-1];
   assign sh       = {fill, data[WIDTH-1:1]};

   // Pad by filling everything first, then overlaying the operand bits;
   // this also stays legal when OUT_WIDTH equals WIDTH.
   always_comb begin
      ext_in              = {OUT_WIDTH{arith & in[WIDTH-1]}};
      ext_in[WIDTH-1:0]   = in;
      ext_sh              = {OUT_WIDTH{fill}};
      ext_sh[WIDTH-1:0]   = sh;
   end

   always_comb begin
      state_n = state;
      data_n  = data;
      rem_n   = rem;
      mode_n  = mode;
      out_n   = out;
      ov_n    = out_valid;
      if (clear) begin
         state_n = IDLE;
         data_n  = '0;
         rem_n   = '0;
         out_n   = '0;
         ov_n    = 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  data_n = in;
                  mode_n = arith;
                  rem_n  = eff;
                  if (eff == '0) begin
                     state_n = DONE;
                     out_n   = ext_in;
                     ov_n    = 1'b1;
                  end else begin
                     state_n = SHIFT;
                  end
               end
            end
            SHIFT: begin
               data_n = sh;
               rem_n  = rem - 1'b1;
               if (rem == CNT_W'(1)) begin
                  state_n = DONE;
                  out_n   = ext_sh;
                  ov_n    = 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_n = IDLE;
                  ov_n    = 1'b0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         data      <= '0;
         rem       <= '0;
         mode      <= 1'b0;
         out       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         data      <= data_n;
         rem       <= rem_n;
         mode      <= mode_n;
         out       <= out_n;
         out_valid <= ov_n;
         busy      <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Directed bench for shift_right_sequencer.
// Each task drives one scenario and checks its own expectations.
module tb_shift_right_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in;
   logic [4:0]  shamt;
   logic        arith;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   shift_right_sequencer #(
      .WIDTH(16),
      .OUT_WIDTH(32),
      .CNT_W(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in(in),
      .shamt(shamt),
      .arith(arith),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out(out),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [15:0] a, input logic [4:0] s,
                         input logic ar, input string nm);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s in_ready before accept: got %b want 1", nm, in_ready);
      end
      in       = a;
      shamt    = s;
      arith    = ar;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Accept, wait for result with out_ready=1, check latency/value/consume.
   task automatic run_op(input logic [15:0] a, input logic [4:0] s,
                         input logic ar, input logic [31:0] exp,
                         input int lat, input string nm);
      int n;
      out_ready = 1'b1;
      accept(a, s, ar, nm);
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n !== lat) begin
         failures++;
         $display("FAIL %s latency: got %0d want %0d", nm, n, lat);
      end
      checks++;
      if (out !== exp) begin
         failures++;
         $display("FAIL %s out: got %h want %h", nm, out, exp);
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s done flags: busy=%b in_ready=%b want 1 0",
                  nm, busy, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== exp) begin
         failures++;
         $display("FAIL %s consume: ov=%b rdy=%b out=%h want 0 1 %h",
                  nm, out_valid, in_ready, out, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      checks++;
      if (out !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0 ||
          in_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset state: out=%h ov=%b busy=%b rdy=%b want 0 0 0 0",
                  out, out_valid, busy, in_ready);
      end
      tick();
      tick();
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset release in_ready: got %b want 1", in_ready);
      end
      tick();
   endtask

   task automatic test_logical();
      run_op(16'hF0F0, 5'd4, 1'b0, 32'h0000_0F0F, 4, "logical4");
      run_op(16'hABCD, 5'd1, 1'b0, 32'h0000_55E6, 1, "logical1");
   endtask

   task automatic test_arith();
      run_op(16'h8000, 5'd15, 1'b1, 32'hFFFF_FFFF, 15, "arith15");
      run_op(16'h7000, 5'd3, 1'b1, 32'h0000_0E00, 3, "arith_pos");
      run_op(16'hC000, 5'd2, 1'b1, 32'hFFFF_F000, 2, "arith_neg");
   endtask

   task automatic test_zero_shift();
      run_op(16'h1234, 5'd0, 1'b0, 32'h0000_1234, 0, "zero_log");
      run_op(16'h8001, 5'd0, 1'b1, 32'hFFFF_8001, 0, "zero_ari");
   endtask

   task automatic test_saturate();
      run_op(16'hFFFF, 5'd20, 1'b0, 32'h0000_0000, 16, "sat_log");
      run_op(16'h8001, 5'd31, 1'b1, 32'hFFFF_FFFF, 16, "sat_ari");
      run_op(16'h8001, 5'd16, 1'b0, 32'h0000_0000, 16, "sat_16");
   endtask

   task automatic test_back_to_back();
      run_op(16'h00F0, 5'd4, 1'b0, 32'h0000_000F, 4, "b2b_a");
      run_op(16'h0F00, 5'd8, 1'b0, 32'h0000_000F, 8, "b2b_b");
      run_op(16'h0002, 5'd1, 1'b0, 32'h0000_0001, 1, "b2b_c");
   endtask

   task automatic test_clear();
      int pulses;
      out_ready = 1'b1;
      run_op(16'h5555, 5'd0, 1'b0, 32'h0000_5555, 0, "pre_clear");
      accept(16'hFF00, 5'd8, 1'b0, "clear_op");
      tick();
      clear    = 1'b1;
      in       = 16'h1111;
      shamt    = 5'd0;
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL clear in_ready: got %b want 0", in_ready);
      end
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (out !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0 ||
          in_ready !== 1'b1) begin
         failures++;
         $display("FAIL clear state: out=%h ov=%b busy=%b rdy=%b want 0 0 0 1",
                  out, out_valid, busy, in_ready);
      end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL clear no_pulse: got %0d pulses want 0", pulses);
      end
   endtask

   task automatic test_hold_and_reset();
      int n;
      int bad;
      int pulses;
      out_ready = 1'b0;
      accept(16'hABCD, 5'd2, 1'b0, "hold");
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 2 || out !== 32'h0000_2AF3) begin
         failures++;
         $display("FAIL hold result: lat=%0d out=%h want 2 00002af3", n, out);
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (out_valid !== 1'b1 || out !== 32'h0000_2AF3 ||
             in_ready !== 1'b0 || busy !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL hold stable: got %0d bad cycles want 0", bad);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || out !== 32'h0000_2AF3) begin
         failures++;
         $display("FAIL hold release: ov=%b out=%h want 0 00002af3",
                  out_valid, out);
      end
      accept(16'h8888, 5'd10, 1'b1, "mid_reset");
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out !== 32'h0 || out_valid !== 1'b0 || busy !== 1'b0 ||
          in_ready !== 1'b0) begin
         failures++;
         $display("FAIL async reset: out=%h ov=%b busy=%b rdy=%b want 0 0 0 0",
                  out, out_valid, busy, in_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid) pulses++;
      end
      checks++;
      if (pulses !== 0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL post reset: pulses=%0d rdy=%b want 0 1",
                  pulses, in_ready);
      end
   endtask

   initial begin
      reset     = 1'b1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in        = '0;
      shamt     = '0;
      arith     = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_logical();
      test_arith();
      test_zero_shift();
      test_saturate();
      test_back_to_back();
      test_clear();
      test_hold_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
